// File: rtl/btn_cond_if.sv
// Raw board inputs and conditioned control outputs of the button conditioner.
interface btn_cond_if;
    logic start_raw;
    logic act_raw;
    logic finish_raw;
    logic mode_raw;
    logic start;
    logic act;
    logic finish_test;
    logic mode;

    modport master (
        output start_raw, act_raw, finish_raw, mode_raw,
        input  start, act, finish_test, mode
    );
    modport slave (
        input  start_raw, act_raw, finish_raw, mode_raw,
        output start, act, finish_test, mode
    );
endinterface

// File: rtl/btn_cond.sv
// Button/switch conditioner: per-channel 2-flop sync, 4-state debounce FSM,
// and either a one-cycle press pulse or a debounced level output.
module btn_cond_ch #(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int CNT_W        = 20,
    parameter bit IS_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic out
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] P_WAIT = 2'd1;
    localparam logic [1:0] HELD   = 2'd2;
    localparam logic [1:0] R_WAIT = 2'd3;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             fire;

    always_comb begin
        meta_d  = raw;
        sync_d  = meta_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync_q) begin
                    state_d = P_WAIT;
                    cnt_d   = '0;
                end
            end
            P_WAIT: begin
                if (!sync_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = HELD;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!sync_q) begin
                    state_d = R_WAIT;
                    cnt_d   = '0;
                end
            end
            R_WAIT: begin
                // Bounce back to HELD never re-fires: only P_WAIT->HELD pulses.
                if (sync_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        out_d = IS_LEVEL ? ((state_d == HELD) || (state_d == R_WAIT)) : fire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign out = out_q;
endmodule

module btn_cond #(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int CNT_W        = 20
) (
    input logic       clk,
    input logic       rst,
    btn_cond_if.slave bus
);
    localparam int NUM_CH = 4;

    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] out_vec;

    // Lane order: 0 start, 1 act, 2 finish, 3 mode (level output).
    assign raw_vec = {bus.mode_raw, bus.finish_raw, bus.act_raw, bus.start_raw};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        btn_cond_ch #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .CNT_W       (CNT_W),
            .IS_LEVEL    (i == NUM_CH - 1)
        ) u_ch (
            .clk(clk),
            .rst(rst),
            .raw(raw_vec[i]),
            .out(out_vec[i])
        );
    end

    assign bus.start       = out_vec[0];
    assign bus.act         = out_vec[1];
    assign bus.finish_test = out_vec[2];
    assign bus.mode        = out_vec[3];
endmodule

// File: tb/tb_btn_cond.sv
// Directed bench for btn_cond: run-length debounce model checked every cycle,
// plus hand-computed pulse edges and counts per scenario.
module tb_btn_cond;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;
    btn_cond_if bus ();

    btn_cond #(.DEBOUNCE_CYC(D), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int t0  = 0;
    int passed = 0;
    int total  = 0;
    int n_p[3];
    int last_p[3];

    // Model: the debounce sees raw delayed two edges; the level flips once
    // D+1 consecutive samples disagree with it.
    bit [3:0] h1, h2, lvl;
    int       run[4];
    bit [2:0] exp_pulse;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h1 = '0; h2 = '0; lvl = '0; exp_pulse = '0;
            for (int c = 0; c < 4; c++) run[c] = 0;
        end else begin
            exp_pulse = '0;
            for (int c = 0; c < 4; c++) begin
                if (h2[c] != lvl[c]) begin
                    run[c] = run[c] + 1;
                    if (run[c] == D + 1) begin
                        lvl[c] = ~lvl[c];
                        run[c] = 0;
                        if (lvl[c] && c < 3) exp_pulse[c] = 1'b1;
                    end
                end else begin
                    run[c] = 0;
                end
            end
            h2 = h1;
            h1 = {bus.mode_raw, bus.finish_raw, bus.act_raw, bus.start_raw};
        end
    end

    task automatic chk_bit(input string nm, input logic act_v, input logic exp_v);
        total = total + 1;
        if (act_v === exp_v) passed = passed + 1;
        else $display("FAIL %s: got %b want %b (edge %0d)", nm, act_v, exp_v, cyc);
    endtask

    task automatic chk_int(input string nm, input int act_v, input int exp_v);
        total = total + 1;
        if (act_v == exp_v) passed = passed + 1;
        else $display("FAIL %s: got %0d want %0d (edge %0d)", nm, act_v, exp_v, cyc);
    endtask

    always @(negedge clk) begin
        chk_bit("start",       bus.start,       exp_pulse[0]);
        chk_bit("act",         bus.act,         exp_pulse[1]);
        chk_bit("finish_test", bus.finish_test, exp_pulse[2]);
        chk_bit("mode",        bus.mode,        lvl[3]);
        if (bus.start)       begin n_p[0] = n_p[0] + 1; last_p[0] = cyc; end
        if (bus.act)         begin n_p[1] = n_p[1] + 1; last_p[1] = cyc; end
        if (bus.finish_test) begin n_p[2] = n_p[2] + 1; last_p[2] = cyc; end
    end

    // Returns at the negedge just before test-relative edge j.
    task automatic at(input int j);
        while (cyc < t0 + j - 1) @(negedge clk);
    endtask

    task automatic new_test();
        @(negedge clk);
        t0 = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0, n1, f;
        bit pat[6];
        for (int c = 0; c < 3; c++) begin n_p[c] = 0; last_p[c] = 0; end
        bus.start_raw = 0; bus.act_raw = 0; bus.finish_raw = 0; bus.mode_raw = 0;
        rst = 1'b1;
        #1;
        chk_bit("reset_act",  bus.act,  1'b0);
        chk_bit("reset_mode", bus.mode, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Clean press
        new_test(); n0 = n_p[1];
        at(10); bus.act_raw = 1;
        at(40); bus.act_raw = 0;
        at(60);
        chk_int("t1_act_count", n_p[1] - n0, 1);
        chk_int("t1_act_edge",  last_p[1] - t0, 16);

        // Bounce on press, then bouncy release with short re-press
        new_test(); n0 = n_p[0];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin at(15 + i); bus.start_raw = pat[i]; end
        at(38);
        chk_int("t2_start_count", n_p[0] - n0, 1);
        chk_int("t2_start_edge",  last_p[0] - t0, 26);
        at(40); bus.start_raw = 0;
        at(43); bus.start_raw = 1;
        at(45); bus.start_raw = 0;
        at(48); bus.start_raw = 1;
        at(50); bus.start_raw = 0;
        at(70);
        chk_int("t2_no_repeat", n_p[0] - n0, 1);

        // Glitch, then a clean press qualifying from IDLE
        new_test(); n0 = n_p[2];
        at(10); bus.finish_raw = 1;
        at(14); bus.finish_raw = 0;
        at(30);
        chk_int("t3_glitch", n_p[2] - n0, 0);
        bus.finish_raw = 1;
        at(50); bus.finish_raw = 0;
        at(60);
        chk_int("t3_press_count", n_p[2] - n0, 1);
        chk_int("t3_press_edge",  last_p[2] - t0, 36);

        // Simultaneous presses
        new_test(); n0 = n_p[0]; n1 = n_p[1];
        at(5); bus.start_raw = 1; bus.act_raw = 1;
        at(25); bus.start_raw = 0; bus.act_raw = 0;
        at(40);
        chk_int("t4_start_count", n_p[0] - n0, 1);
        chk_int("t4_act_count",   n_p[1] - n1, 1);
        chk_int("t4_start_edge",  last_p[0] - t0, 11);
        chk_int("t4_act_edge",    last_p[1] - t0, 11);

        // Mode level; edge 0 is the first edge sampling the switch high
        @(negedge clk); t0 = cyc + 1;
        bus.mode_raw = 1;
        at(6); chk_bit("t5_mode_e5", bus.mode, 1'b0);
        at(7); chk_bit("t5_mode_e6", bus.mode, 1'b1);
        at(36); bus.mode_raw = 0;
        at(38); bus.mode_raw = 1;
        at(40); bus.mode_raw = 0;
        at(46); chk_bit("t5_mode_e45", bus.mode, 1'b1);
        at(47); chk_bit("t5_mode_e46", bus.mode, 1'b0);

        // Async reset mid-qualification, released with act still held
        new_test(); n0 = n_p[1];
        at(1); bus.mode_raw = 1;
        at(12); chk_bit("t6_mode_pre", bus.mode, 1'b1);
        bus.act_raw = 1;
        at(16);
        #2 rst = 1'b1;
        #1;
        chk_bit("t6_rst_mode",  bus.mode,        1'b0);
        chk_bit("t6_rst_act",   bus.act,         1'b0);
        chk_bit("t6_rst_start", bus.start,       1'b0);
        chk_bit("t6_rst_fin",   bus.finish_test, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        f = cyc + 1;
        while (cyc < f + 12) @(negedge clk);
        chk_int("t6_act_count", n_p[1] - n0, 1);
        chk_int("t6_act_edge",  last_p[1] - f, D + 2);
        chk_bit("t6_mode_post", bus.mode, 1'b1);
        bus.act_raw = 0; bus.mode_raw = 0;
        repeat (15) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
